// File: rtl/free_list.sv
// R10K free list: circular FIFO of free physical tags with per-branch head checkpoints.
// Retire pushes t_old tags at the tail; dispatch pops up to N tags from the head.
`ifndef N
`define N 3
`endif
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif

package free_list_pkg;
  typedef logic [$clog2(`PHYS_REG_SZ_R10K)-1:0] PHYS_REG_IDX;

  typedef struct packed {
    logic [4:0]  dest_reg_idx;
    PHYS_REG_IDX t;
    PHYS_REG_IDX t_old;
  } ROB_PACKET;
endpackage

module free_list
  import free_list_pkg::*;
#(
  parameter int N         = `N,
  parameter int PHYS_REGS = `PHYS_REG_SZ_R10K,
  parameter int ARCH_REGS = 32,
  parameter int DEPTH     = PHYS_REGS - ARCH_REGS,
  localparam int PTR_W    = $clog2(DEPTH) + 1,
  localparam int CNT_W    = $clog2(N + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [CNT_W-1:0]       num_alloc,
  output PHYS_REG_IDX [N-1:0]    alloc_t,
  output logic [CNT_W-1:0]       num_avail,
  input  ROB_PACKET [N-1:0]      retiring_data,
  input  logic [CNT_W-1:0]       num_retired,
  input  logic                   br_en,
  input  logic [PTR_W-1:0]       br_head,
  output logic [PTR_W-1:0]       out_head,
  output logic [PTR_W-1:0]       count
);

  localparam int IDX_W = PTR_W - 1;

  PHYS_REG_IDX       entries [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  base;
  logic [PTR_W-1:0]  rd_ptr;
  logic [N-1:0]      lane_free;
  logic [CNT_W-1:0]  lane_slot [N];
  logic [IDX_W-1:0]  wr_idx [N];
  logic [CNT_W-1:0]  num_freed;
  logic              unused_rob_t;

  assign count    = tail - head;
  assign out_head = head;
  assign base     = br_en ? br_head : head;
  assign num_avail = (count >= PTR_W'(N)) ? CNT_W'(N) : count[CNT_W-1:0];

  always_comb begin
    rd_ptr = head;
    for (int j = 0; j < N; j++) begin
      rd_ptr     = head + PTR_W'(j);
      alloc_t[j] = entries[rd_ptr[IDX_W-1:0]];
    end
  end

  // Compact the valid, register-writing retire lanes onto consecutive tail slots.
  always_comb begin
    num_freed    = '0;
    unused_rob_t = 1'b0;
    for (int i = 0; i < N; i++) begin
      lane_free[i] = (CNT_W'(i) < num_retired) && (retiring_data[i].dest_reg_idx != '0);
      lane_slot[i] = num_freed;
      wr_idx[i]    = IDX_W'(tail + PTR_W'(num_freed));
      num_freed    = num_freed + CNT_W'(lane_free[i]);
      unused_rob_t = unused_rob_t ^ (^retiring_data[i].t);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= PTR_W'(DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= PHYS_REG_IDX'(ARCH_REGS + i);
      end
    end else begin
      head <= base + PTR_W'(num_alloc);
      tail <= tail + PTR_W'(num_freed);
      for (int i = 0; i < N; i++) begin
        if (lane_free[i]) begin
          entries[wr_idx[i]] <= retiring_data[i].t_old;
        end
      end
    end
  end

`ifdef DEBUG
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (num_alloc <= num_avail);
      assert (!(br_en && (num_alloc != '0)));
      assert (num_retired <= CNT_W'(N));
      assert (({1'b0, count} + (PTR_W+1)'(num_freed)) <= (PTR_W+1)'(DEPTH));
    end
  end
`endif

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list (N=3, 64 phys, 32 arch, depth 32) with a queue-based scoreboard.
module tb_free_list;
  import free_list_pkg::*;

  logic              clock;
  logic              reset;
  logic [1:0]        num_alloc;
  PHYS_REG_IDX [2:0] alloc_t;
  logic [1:0]        num_avail;
  ROB_PACKET [2:0]   rd;
  logic [1:0]        num_retired;
  logic              br_en;
  logic [5:0]        br_head;
  logic [5:0]        out_head;
  logic [5:0]        count;

  free_list #(.N(3), .PHYS_REGS(64), .ARCH_REGS(32), .DEPTH(32)) dut (
    .clock(clock), .reset(reset), .num_alloc(num_alloc), .alloc_t(alloc_t),
    .num_avail(num_avail), .retiring_data(rd), .num_retired(num_retired),
    .br_en(br_en), .br_head(br_head), .out_head(out_head), .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string           name;
    logic [2:0]      amask;
    logic [2:0][5:0] alloc;
    int              avail;
    int              cnt;
    int              head;
  } exp_t;

  exp_t sb[$];
  event sample_ev;
  int   vectors = 0;
  int   miscompares = 0;

  // Monitor: compares every queued expectation against the DUT when sampled.
  exp_t e;
  initial begin
    forever begin
      @(negedge clock or sample_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        for (int j = 0; j < 3; j++) begin
          if (e.amask[j]) begin
            vectors++;
            if (alloc_t[j] !== e.alloc[j]) begin
              miscompares++;
              $display("FAIL %s alloc_t[%0d]: got %0d expected %0d", e.name, j, alloc_t[j], e.alloc[j]);
            end
          end
        end
        if (e.avail >= 0) begin
          vectors++;
          if (int'(num_avail) != e.avail) begin
            miscompares++;
            $display("FAIL %s num_avail: got %0d expected %0d", e.name, num_avail, e.avail);
          end
        end
        if (e.cnt >= 0) begin
          vectors++;
          if (int'(count) != e.cnt) begin
            miscompares++;
            $display("FAIL %s count: got %0d expected %0d", e.name, count, e.cnt);
          end
        end
        if (e.head >= 0) begin
          vectors++;
          if (int'(out_head) != e.head) begin
            miscompares++;
            $display("FAIL %s out_head: got %0d expected %0d", e.name, out_head, e.head);
          end
        end
      end
    end
  end

  task automatic push_exp(input string nm, input logic [2:0] m, input int a0, input int a1,
                          input int a2, input int av, input int cnt, input int hd);
    exp_t x;
    x.name = nm; x.amask = m;
    x.alloc[0] = 6'(a0); x.alloc[1] = 6'(a1); x.alloc[2] = 6'(a2);
    x.avail = av; x.cnt = cnt; x.head = hd;
    sb.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [2:0] m, input int a0, input int a1,
                     input int a2, input int av, input int cnt, input int hd);
    push_exp(nm, m, a0, a1, a2, av, cnt, hd);
    @(negedge clock);
    #1;
  endtask

  task automatic cycle(input int na, input int nr, input int d0, input int d1, input int d2,
                       input int o0, input int o1, input int o2, input bit br, input int bh);
    num_alloc = 2'(na);
    num_retired = 2'(nr);
    rd = '0;
    rd[0].dest_reg_idx = 5'(d0); rd[0].t_old = 6'(o0);
    rd[1].dest_reg_idx = 5'(d1); rd[1].t_old = 6'(o1);
    rd[2].dest_reg_idx = 5'(d2); rd[2].t_old = 6'(o2);
    br_en = br;
    br_head = 6'(bh);
    @(posedge clock);
    #1;
    num_alloc = '0; num_retired = '0; rd = '0; br_en = 1'b0; br_head = '0;
  endtask

  task automatic alloc(input int n);
    cycle(n, 0, 0, 0, 0, 0, 0, 0, 1'b0, 0);
  endtask

  // Contents after the first retire: idx 0/1 hold 40/41, the rest keep reset values.
  function automatic int early_val(input int idx);
    if (idx == 0) return 40;
    if (idx == 1) return 41;
    return 32 + idx;
  endfunction

  initial begin
    int c, hd;
    logic [2:0] m;
    reset = 1'b1;
    num_alloc = '0; num_retired = '0; rd = '0; br_en = 1'b0; br_head = '0;
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;

    chk("reset", 3'b111, 32, 33, 34, 3, 32, 0);
    alloc(3);
    chk("first_alloc", 3'b111, 35, 36, 37, 3, 29, 3);

    // Lane 1 has dest 0 and must not free tag 9.
    cycle(0, 3, 5, 0, 7, 40, 9, 41, 1'b0, 0);
    chk("retire_skip", 3'b111, 35, 36, 37, 3, 31, 3);

    for (int k = 1; k <= 10; k++) begin
      c  = 31 - 3 * k;
      hd = 3 + 3 * k;
      m  = (c >= 3) ? 3'b111 : (c == 2) ? 3'b011 : (c == 1) ? 3'b001 : 3'b000;
      alloc(3);
      chk("drain", m, early_val(hd % 32), early_val((hd + 1) % 32), early_val((hd + 2) % 32),
          (c >= 3) ? 3 : c, c, hd);
    end
    alloc(1);
    chk("empty", 3'b000, 0, 0, 0, 0, 0, 34);

    cycle(0, 1, 3, 0, 0, 50, 0, 0, 1'b0, 0);
    chk("refill_one", 3'b001, 50, 0, 0, 1, 1, 34);

    for (int k = 0; k < 9; k++) begin
      cycle(0, 3, 1, 2, 3, 5 + 3 * k, 6 + 3 * k, 7 + 3 * k, 1'b0, 0);
      chk("refill", 3'b000, 0, 0, 0, 3, 4 + 3 * k, 34);
    end
    cycle(0, 2, 0, 4, 0, 1, 32, 0, 1'b0, 0);
    chk("partial_retire", 3'b000, 0, 0, 0, 3, 29, 34);

    // Tail index 31: three tags land at indices 31, 0, 1 and the list becomes full.
    cycle(0, 3, 5, 6, 7, 20, 21, 22, 1'b0, 0);
    chk("wrap_free_full", 3'b111, 50, 5, 6, 3, 32, 34);

    for (int k = 1; k <= 9; k++) begin
      alloc(3);
      chk("walk", 3'b000, 0, 0, 0, 3, 32 - 3 * k, 34 + 3 * k);
    end
    alloc(2);
    chk("wrap_read", 3'b111, 20, 21, 22, 3, 3, 63);
    alloc(3);
    chk("wrap_empty", 3'b000, 0, 0, 0, 0, 0, 2);

    for (int k = 0; k < 4; k++) begin
      cycle(0, 3, 1, 1, 1, 40 + 3 * k, 41 + 3 * k, 42 + 3 * k, 1'b0, 0);
      chk("br_fill", 3'b000, 0, 0, 0, 3, 3 + 3 * k, 2);
    end
    chk("br_fill_tags", 3'b111, 40, 41, 42, 3, 12, 2);
    alloc(3);
    alloc(1);
    chk("checkpoint", 3'b111, 44, 45, 46, 3, 8, 6);
    alloc(3);
    alloc(3);
    chk("post_ckpt", 3'b011, 50, 51, 0, 2, 2, 12);
    cycle(0, 1, 9, 0, 0, 60, 0, 0, 1'b1, 6);
    chk("br_restore", 3'b111, 44, 45, 46, 3, 9, 6);
    cycle(0, 1, 9, 0, 0, 61, 0, 0, 1'b0, 0);
    chk("pre_reset", 3'b000, 0, 0, 0, 3, 10, 6);

    // Asynchronous reset between edges; sampled before the next rising edge.
    #2 reset = 1'b1;
    #1;
    push_exp("async_reset", 3'b111, 32, 33, 34, 3, 32, 0);
    -> sample_ev;
    @(negedge clock);
    #1 reset = 1'b0;
    alloc(3);
    chk("after_reset", 3'b111, 35, 36, 37, 3, 29, 3);

    repeat (2) @(negedge clock);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
